// File: rtl/tdm_serializer.sv
// tdm_serializer: transmit side of the TDM link.
// Takes one 5 x 16-bit sample set through a valid/ready handshake and sends it as one frame:
// a one-slot sync marker, then 80 data bits (ch0..ch4, MSB first).
// A one-deep shadow register lets the next sample set wait while the current frame is sent,
// so frames can go out back to back.
module tdm_serializer #(
  parameter int unsigned SIZE_16T = 16,
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAP_BITS = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [SIZE_16T-1:0] ch0_in,
  input  logic [SIZE_16T-1:0] ch1_in,
  input  logic [SIZE_16T-1:0] ch2_in,
  input  logic [SIZE_16T-1:0] ch3_in,
  input  logic [SIZE_16T-1:0] ch4_in,
  output logic                tdm_clk,
  output logic                tdm_sync,
  output logic                tdm_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned FRAME_BITS = SIZE_16T * NUM_CH;
  localparam int unsigned DIV_W      = $clog2(CLK_DIV);
  localparam int unsigned DIV_LAST   = CLK_DIV - 1;
  localparam int unsigned DIV_HALF   = CLK_DIV / 2;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned FRAME_LAST = FRAME_BITS - 1;
  localparam int unsigned GAP_W      = 8;
  localparam int unsigned GAP_LAST   = (GAP_BITS > 0) ? (GAP_BITS - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Bit-clock divider
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  clk_q, clk_d;
  logic                  slot_start_c;

  // Shadow register and handshake
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic                  shadow_full_q, shadow_full_d;
  logic                  ready_q, ready_d;
  logic                  hs_c;
  logic                  xfer_c;

  // Frame sequencer
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shifter_q, shifter_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  sync_q, sync_d;
  logic                  data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  go_idle_c;

  // Divider next state; a slot starts on the edge where the count wraps to zero (tdm_clk falls)
  always_comb begin
    slot_start_c = (div_q == DIV_W'(DIV_LAST));
    div_d        = slot_start_c ? '0 : (div_q + DIV_W'(1));
    clk_d        = (div_d >= DIV_W'(DIV_HALF));
  end

  // Shadow register: capture on handshake, release when the sequencer takes the frame
  always_comb begin
    hs_c          = load_valid && ready_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    if (hs_c) begin
      shadow_d      = {ch0_in, ch1_in, ch2_in, ch3_in, ch4_in};
      shadow_full_d = 1'b1;
    end else if (xfer_c) begin
      shadow_full_d = 1'b0;
    end
    ready_d = ~shadow_full_d;
  end

  // Frame sequencer next state and slot outputs; everything moves only at slot starts
  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    sync_d    = sync_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    xfer_c    = 1'b0;
    go_idle_c = 1'b0;

    if (slot_start_c) begin
      unique case (state_q)
        ST_IDLE: begin
          go_idle_c = 1'b1;
        end
        ST_SYNC: begin
          state_d   = ST_SHIFT;
          bit_d     = '0;
          sync_d    = 1'b0;
          data_d    = shifter_q[FRAME_BITS-1];
          shifter_d = {shifter_q[FRAME_BITS-2:0], 1'b0};
        end
        ST_SHIFT: begin
          if (bit_q == BIT_W'(FRAME_LAST)) begin
            done_d = 1'b1;
            if (GAP_BITS > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
              sync_d  = 1'b0;
              data_d  = 1'b0;
            end else begin
              go_idle_c = 1'b1;
            end
          end else begin
            bit_d     = bit_q + BIT_W'(1);
            data_d    = shifter_q[FRAME_BITS-1];
            shifter_d = {shifter_q[FRAME_BITS-2:0], 1'b0};
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_LAST)) begin
            go_idle_c = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: begin
          go_idle_c = 1'b1;
        end
      endcase

      // Idle decision: a waiting shadow starts the next frame in this very slot
      if (go_idle_c) begin
        if (shadow_full_q) begin
          xfer_c    = 1'b1;
          shifter_d = shadow_q;
          state_d   = ST_SYNC;
          sync_d    = 1'b1;
          data_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
          sync_d  = 1'b0;
          data_d  = 1'b0;
        end
      end

      busy_d = (state_d != ST_IDLE);
    end
  end

  // State registers; reset aborts any frame in flight and discards the shadow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      clk_q         <= 1'b0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      ready_q       <= 1'b1;
      state_q       <= ST_IDLE;
      shifter_q     <= '0;
      bit_q         <= '0;
      gap_q         <= '0;
      sync_q        <= 1'b0;
      data_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      div_q         <= div_d;
      clk_q         <= clk_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      ready_q       <= ready_d;
      state_q       <= state_d;
      shifter_q     <= shifter_d;
      bit_q         <= bit_d;
      gap_q         <= gap_d;
      sync_q        <= sync_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign load_ready = ready_q;
  assign tdm_clk    = clk_q;
  assign tdm_sync   = sync_q;
  assign tdm_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tdm_serializer.sv
// Bench for tdm_serializer: one instance at CLK_DIV=4/no gap, one at CLK_DIV=2/GAP_BITS=3.
module tb_tdm_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: CLK_DIV=4, GAP_BITS=0
  logic        lv_a, lr_a, tclk_a, sync_a, data_a, busy_a, done_a;
  logic [15:0] c0_a, c1_a, c2_a, c3_a, c4_a;
  // Instance B: CLK_DIV=2, GAP_BITS=3
  logic        lv_b, lr_b, tclk_b, sync_b, data_b, busy_b, done_b;
  logic [15:0] c0_b, c1_b, c2_b, c3_b, c4_b;

  tdm_serializer #(.CLK_DIV(4), .GAP_BITS(0)) u_dut_a (
    .clock(clk), .reset(rst_n), .load_valid(lv_a), .load_ready(lr_a),
    .ch0_in(c0_a), .ch1_in(c1_a), .ch2_in(c2_a), .ch3_in(c3_a), .ch4_in(c4_a),
    .tdm_clk(tclk_a), .tdm_sync(sync_a), .tdm_data(data_a), .busy(busy_a), .frame_done(done_a)
  );

  tdm_serializer #(.CLK_DIV(2), .GAP_BITS(3)) u_dut_b (
    .clock(clk), .reset(rst_n), .load_valid(lv_b), .load_ready(lr_b),
    .ch0_in(c0_b), .ch1_in(c1_b), .ch2_in(c2_b), .ch3_in(c3_b), .ch4_in(c4_b),
    .tdm_clk(tclk_b), .tdm_sync(sync_b), .tdm_data(data_b), .busy(busy_b), .frame_done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                        input logic [15:0] a3, input logic [15:0] a4);
    c0_a = a0; c1_a = a1; c2_a = a2; c3_a = a3; c4_a = a4;
    lv_a = 1'b1;
    tick();
    lv_a = 1'b0;
  endtask

  task automatic wait_sync_a(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (sync_a) begin
        at = cyc;
        break;
      end
      tick();
    end
    check_eq("sync_seen_a", 32'(sync_a), 32'd1);
  endtask

  // Loopback receiver on instance A: sample at tdm_clk rise
  logic [79:0] rx_frame [8];
  logic [79:0] rx_sr;
  int          rx_cnt = 0;
  int          rx_bits;
  bit          rx_on;

  always @(posedge tclk_a or negedge rst_n) begin
    if (!rst_n) begin
      rx_on   = 1'b0;
      rx_bits = 0;
    end else if (sync_a) begin
      rx_on   = 1'b1;
      rx_bits = 0;
    end else if (rx_on) begin
      rx_sr = {rx_sr[78:0], data_a};
      rx_bits++;
      if (rx_bits == 80) begin
        if (rx_cnt < 8) rx_frame[rx_cnt] = rx_sr;
        rx_cnt++;
        rx_on = 1'b0;
      end
    end
  end

  // Line changes must coincide with tdm_clk falling (high one clock earlier, low now)
  logic       prev_rst = 1'b0;
  logic [1:0] prev_sd_a = 2'b00, prev_sd_b = 2'b00;
  logic       prev_clk_a = 1'b0, prev_clk_b = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (rst_n && prev_rst) begin
      if ({sync_a, data_a} != prev_sd_a) check_eq("edge_a", {30'd0, prev_clk_a, tclk_a}, 32'd2);
      if ({sync_b, data_b} != prev_sd_b) check_eq("edge_b", {30'd0, prev_clk_b, tclk_b}, 32'd2);
    end
    prev_rst   = rst_n;
    prev_sd_a  = {sync_a, data_a};
    prev_sd_b  = {sync_b, data_b};
    prev_clk_a = tclk_a;
    prev_clk_b = tclk_b;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0, c1, c2, c3, fd_at, n_sync, n_fd, n_rdy, n_busy, nr, off;
    int          rise [3];
    logic        last_rdy, prev_sync;
    logic [79:0] f;

    rst_n = 1'b0;
    lv_a = 1'b0; lv_b = 1'b0;
    c0_a = '0; c1_a = '0; c2_a = '0; c3_a = '0; c4_a = '0;
    c0_b = 16'h8001; c1_b = 16'h1234; c2_b = 16'h5678; c3_b = 16'h9ABC; c4_b = 16'hFFFF;

    // Reset state
    #22;
    check_eq("rst_tclk", 32'(tclk_a), 32'd0);
    check_eq("rst_sync", 32'(sync_a), 32'd0);
    check_eq("rst_data", 32'(data_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_ready", 32'(lr_a), 32'd1);
    tick();

    // Single frame and loopback
    load_a(16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234);
    check_eq("ready_after_load", 32'(lr_a), 32'd0);
    wait_sync_a(20, c0);
    check_eq("busy_at_sync", 32'(busy_a), 32'd1);
    check_eq("ready_at_sync", 32'(lr_a), 32'd1);
    n_sync = 1; n_fd = 0; fd_at = 0;
    for (int k = 1; k < 340; k++) begin
      tick();
      if (sync_a) n_sync++;
      if (done_a) begin
        n_fd++;
        fd_at = cyc;
      end
    end
    check_eq("sync_len", 32'(n_sync), 32'd4);
    check_eq("done_count", 32'(n_fd), 32'd1);
    check_eq("done_latency", 32'(fd_at - c0), 32'd324);
    check_eq("busy_after", 32'(busy_a), 32'd0);
    check_eq("rx_count1", 32'(rx_cnt), 32'd1);
    f = rx_frame[0];
    check_eq("rx0_ch0", 32'(f[79:64]), 32'h0000A5A5);
    check_eq("rx0_ch1", 32'(f[63:48]), 32'h00000001);
    check_eq("rx0_ch2", 32'(f[47:32]), 32'h00008000);
    check_eq("rx0_ch3", 32'(f[31:16]), 32'h0000FFFF);
    check_eq("rx0_ch4", 32'(f[15:0]),  32'h00001234);

    // Back-to-back with backpressure on the second load
    load_a(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
    wait_sync_a(20, c1);
    repeat (20) tick();
    load_a(16'hCAFE, 16'h0BAD, 16'hF00D, 16'hBEEF, 16'h7E57);
    check_eq("b2b_ready_low", 32'(lr_a), 32'd0);
    c0_a = 16'hDEAD; c1_a = 16'hDEAD; c2_a = 16'hDEAD; c3_a = 16'hDEAD; c4_a = 16'hDEAD;
    lv_a = 1'b1;
    n_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (lr_a) n_rdy++;
    end
    check_eq("bp_ready_cnt", 32'(n_rdy), 32'd0);
    lv_a = 1'b0;
    last_rdy = 1'b1;
    c2 = -1;
    for (int k = 0; k < 400; k++) begin
      if (sync_a) begin
        c2 = cyc;
        break;
      end
      last_rdy = lr_a;
      tick();
    end
    check_eq("sync2_seen", 32'(sync_a), 32'd1);
    check_eq("b2b_period", 32'(c2 - c1), 32'd324);
    check_eq("ready_pre_xfer", 32'(last_rdy), 32'd0);
    check_eq("ready_post_xfer", 32'(lr_a), 32'd1);
    repeat (340) tick();
    check_eq("rx_count3", 32'(rx_cnt), 32'd3);
    f = rx_frame[1];
    check_eq("rx1_ch2", 32'(f[47:32]), 32'h00003333);
    f = rx_frame[2];
    check_eq("rx2_ch0", 32'(f[79:64]), 32'h0000CAFE);
    check_eq("rx2_ch1", 32'(f[63:48]), 32'h00000BAD);
    check_eq("rx2_ch4", 32'(f[15:0]),  32'h00007E57);

    // Reset mid-SHIFT with the shadow also full
    load_a(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_sync_a(20, c3);
    repeat (100) tick();
    load_a(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F);
    check_eq("pre_rst_data", 32'(data_a), 32'd1);
    check_eq("pre_rst_busy", 32'(busy_a), 32'd1);
    check_eq("pre_rst_ready", 32'(lr_a), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_sync", 32'(sync_a), 32'd0);
    check_eq("mid_rst_data", 32'(data_a), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
    check_eq("mid_rst_done", 32'(done_a), 32'd0);
    check_eq("mid_rst_tclk", 32'(tclk_a), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", 32'(lr_a), 32'd1);
    n_sync = 0; n_busy = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (sync_a) n_sync++;
      if (busy_a) n_busy++;
    end
    check_eq("post_rst_no_sync", 32'(n_sync), 32'd0);
    check_eq("post_rst_no_busy", 32'(n_busy), 32'd0);

    // Instance B: continuous loads, gap slots
    lv_b = 1'b1;
    nr = 0;
    prev_sync = sync_b;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (sync_b && !prev_sync) begin
        rise[nr] = cyc;
        nr++;
      end
      prev_sync = sync_b;
      if (nr == 3) break;
      if (nr >= 1) begin
        off = cyc - rise[0];
        if (off == 2 || off == 3 || off == 160 || off == 161) begin
          check_eq("b_data_one", 32'(data_b), 32'd1);
        end else if (off == 4) begin
          check_eq("b_data_bit14", 32'(data_b), 32'd0);
        end else if (off >= 162 && off <= 167) begin
          check_eq("b_gap_data", 32'(data_b), 32'd0);
          check_eq("b_gap_sync", 32'(sync_b), 32'd0);
          check_eq("b_gap_busy", 32'(busy_b), 32'd1);
        end
      end
    end
    lv_b = 1'b0;
    check_eq("b_rises", 32'(nr), 32'd3);
    if (nr == 3) begin
      check_eq("b_period1", 32'(rise[1] - rise[0]), 32'd168);
      check_eq("b_period2", 32'(rise[2] - rise[1]), 32'd168);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
